// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw button input and debounced outputs of debounce_sync
// Carries bounce_cnt only when DEBOUNCE_BOUNCE_CNT_EN is defined.
interface debounce_sync_if;
    logic       btn_in;
    logic       db_level;
    logic       rise_tick;
    logic       fall_tick;
    logic       busy;
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    logic [7:0] bounce_cnt;
`endif

    modport master (
        output btn_in,
        input  db_level,
        input  rise_tick,
        input  fall_tick,
        input  busy
`ifdef DEBOUNCE_BOUNCE_CNT_EN
        , input bounce_cnt
`endif
    );

    modport slave (
        input  btn_in,
        output db_level,
        output rise_tick,
        output fall_tick,
        output busy
`ifdef DEBOUNCE_BOUNCE_CNT_EN
        , output bounce_cnt
`endif
    );
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a raw button and debounces it with a stable-time counter FSM
// Optional DEBOUNCE_BOUNCE_CNT_EN adds a saturating 8-bit count of aborted transitions.
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    debounce_sync_if.slave bus
);
    typedef enum logic [1:0] {ZERO, WAIT_ONE, ONE, WAIT_ZERO} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

    if (SYNC_STAGES < 2 || STABLE_CNT < 1 || (longint'(1) << CNT_W) < longint'(STABLE_CNT)) begin : g_bad_params
        $error("debounce_sync: illegal SYNC_STAGES/STABLE_CNT/CNT_W combination");
    end

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchronizer chain; only its last stage is ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    end

    // Time candidate transitions on s; cnt falls back to 0 whenever a WAIT state is not continuing.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO:     if (s) state_d = WAIT_ONE;
            WAIT_ONE: begin
                if (!s) state_d = ZERO;
                else if (cnt_q == LAST) begin
                    state_d = ONE;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            ONE:      if (!s) state_d = WAIT_ZERO;
            default: begin
                if (s) state_d = ONE;
                else if (cnt_q == LAST) begin
                    state_d = ZERO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
        endcase
        busy_d = (state_d == WAIT_ONE) || (state_d == WAIT_ZERO);
    end

    // Register FSM state, counter and all outputs so downstream logic sees glitch-free levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.db_level  = level_q;
    assign bus.rise_tick = rise_q;
    assign bus.fall_tick = fall_q;
    assign bus.busy      = busy_q;

`ifdef DEBOUNCE_BOUNCE_CNT_EN
    logic       abort;
    logic [7:0] bcnt_q;

    assign abort = (state_q == WAIT_ONE && !s) || (state_q == WAIT_ZERO && s);

    // Count aborted candidates, holding at 255 rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       bcnt_q <= '0;
        else if (abort && bcnt_q != 8'hFF) bcnt_q <= bcnt_q + 8'd1;
    end

    assign bus.bounce_cnt = bcnt_q;
`endif
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: table-driven scoreboard bench for debounce_sync (SYNC_STAGES=2, STABLE_CNT=4)
module tb_debounce_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debounce_sync_if bus();
    debounce_sync #(.SYNC_STAGES(2), .STABLE_CNT(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // exp = {db_level, rise_tick, fall_tick, busy} after the edge
    typedef struct {
        logic       btn;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb[$];
    int         total = 0;
    int         bad = 0;

    function automatic logic [3:0] outs();
        return {bus.db_level, bus.rise_tick, bus.fall_tick, bus.busy};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic b, input logic [3:0] e);
        tbl.push_back('{b, e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before test done");
        $fatal(1);
    end

    initial begin
        // bounce: high 2, low 1, then high and held; first attempt aborts
        add(1, 4'b0000); add(1, 4'b0000); add(0, 4'b0001); add(1, 4'b0001);
        add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001); add(1, 4'b0001);
        add(1, 4'b0001); add(1, 4'b1100); add(1, 4'b1000);
        // clean release from ONE
        add(0, 4'b1000); add(0, 4'b1000); add(0, 4'b1001); add(0, 4'b1001);
        add(0, 4'b1001); add(0, 4'b1001); add(0, 4'b0010); add(0, 4'b0000);
        // clean press from ZERO
        add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0001); add(1, 4'b0001);
        add(1, 4'b0001); add(1, 4'b0001); add(1, 4'b1100); add(1, 4'b1000);
        // 3-cycle low pulse from ONE is shorter than STABLE_CNT and must abort
        add(0, 4'b1000); add(0, 4'b1000); add(0, 4'b1001); add(1, 4'b1001);
        add(1, 4'b1001); add(1, 4'b1000); add(1, 4'b1000); add(1, 4'b1000);

        // reset held with btn high
        bus.btn_in = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("reset_hold", 8'(outs()), 8'h0);
        end
`ifdef DEBOUNCE_BOUNCE_CNT_EN
        check("reset_bcnt", bus.bounce_cnt, 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bus.btn_in = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus.btn_in = tbl[i].btn;
            sb.push_back(tbl[i].exp);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), 8'(outs()), 8'(sb.pop_front()));
`ifdef DEBOUNCE_BOUNCE_CNT_EN
            if (i == 10) check("bcnt_after_bounce", bus.bounce_cnt, 8'd1);
`endif
        end
`ifdef DEBOUNCE_BOUNCE_CNT_EN
        check("bcnt_after_pulse", bus.bounce_cnt, 8'd2);
`endif

        // reset asserted mid WAIT_ZERO, between clock edges
        repeat (3) begin
            @(negedge clk);
            bus.btn_in = 1'b0;
        end
        @(posedge clk); #1;
        check("midwait_busy", 8'(outs()), 8'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 8'(outs()), 8'h0);
`ifdef DEBOUNCE_BOUNCE_CNT_EN
        check("async_bcnt", bus.bounce_cnt, 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("post_reset_idle", 8'(outs()), 8'h0);
        end

        // glitch train: 300 one-cycle highs, period 3
        for (int g = 0; g < 300; g++) begin
            for (int p = 0; p < 3; p++) begin
                @(negedge clk);
                bus.btn_in = (p == 0);
                @(posedge clk); #1;
                check("glitch_no_edge", 8'(outs() >> 1), 8'h0);
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
            check("glitch_tail", 8'(outs()), 8'h0);
        end
`ifdef DEBOUNCE_BOUNCE_CNT_EN
        check("bcnt_saturate", bus.bounce_cnt, 8'd255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
Upstream conditioning stage for the D flip-flop stage. It takes a raw asynchronous mechanical input, such as a push-button or switch, and synchronizes it to clk. It then debounces it with a stable-time counter and FSM. It outputs a clean level that feeds the flip-flop's data input, plus single-cycle rise/fall ticks for downstream counters.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on btn_in; legal range is 2 or more.
STABLE_CNT, 1000000, consecutive synchronized cycles the input must hold before it is accepted (10 ms at 100 MHz); legal range is 1 or more.
CNT_W, 20, stable counter width; must satisfy 2^CNT_W >= STABLE_CNT.

Ports:
clk        input   1  system clock; all state updates on the rising edge.
rst_n      input   1  asynchronous, active-low reset.
btn_in     input   1  raw asynchronous bouncing input.
db_level   output  1  debounced, registered level; this drives the flip-flop data input.
rise_tick  output  1  one-cycle pulse when db_level goes 0->1.
fall_tick  output  1  one-cycle pulse when db_level goes 1->0.
busy       output  1  high while a candidate transition is being timed (WAIT_ONE or WAIT_ZERO).

Behaviour:
- Reset:
  - rst_n low asserts immediately, with no clock required.
  - Synchronizer flops = 0, state = ZERO, cnt = 0.
  - db_level = 0, rise_tick = 0, fall_tick = 0, busy = 0.
  - Release is sampled on the next rising edge.
- Synchronizer:
  - SYNC_STAGES flops in series; s = output of the last stage.
  - The FSM only ever looks at s, never at btn_in.
- FSM states are ZERO, WAIT_ONE, ONE, WAIT_ZERO.
  - ZERO: when s = 1, go to WAIT_ONE and set cnt = 0; otherwise stay.
  - WAIT_ONE:
    - If s = 0, the candidate is aborted as a bounce: go to ZERO, cnt = 0, no tick.
    - Else if cnt == STABLE_CNT-1, go to ONE, db_level <= 1, rise_tick <= 1.
    - Else cnt <= cnt + 1.
  - ONE: when s = 0, go to WAIT_ZERO and set cnt = 0.
  - WAIT_ZERO: mirror of WAIT_ONE.
    - Abort on s = 1: return to ONE, no tick.
    - Accept at cnt == STABLE_CNT-1: go to ZERO, db_level <= 0, fall_tick <= 1.
- Outputs:
  - rise_tick and fall_tick are registered and high for exactly one cycle. They are never high together.
  - busy is registered; it equals (next state is WAIT_ONE or WAIT_ZERO).
- Latency:
  - Condition: btn_in stable at the new value from the first sampling edge onward.
  - db_level and the tick update on edge number SYNC_STAGES + STABLE_CNT + 1, counted from and including the first edge that samples the new value.
  - With defaults, that is 1000003 edges.
- Bounce rule: any reversal of s during a WAIT state restarts timing from zero on the next transition. db_level never toggles for a pulse on s shorter than STABLE_CNT cycles.
- Counter: cnt never exceeds STABLE_CNT-1 and never wraps. It holds 0 outside the WAIT states.
- Reset mid-wait: the FSM returns to ZERO, db_level = 0, and no tick is issued even if db_level was 1.
- STABLE_CNT = 1: a WAIT state lasts exactly one cycle.

Optional Feature:
DEBOUNCE_BOUNCE_CNT_EN
- Defined:
  - Adds output port bounce_cnt [7:0].
  - It increments by 1 on every aborted WAIT_ONE/WAIT_ZERO, on the edge the abort is taken.
  - It saturates at 255 and is reset to 0 by rst_n.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CNT=4, CNT_W=3.
1. Reset: hold rst_n=0 with btn_in=1 for 5 cycles -> all outputs 0. Assert rst_n=0 asynchronously between edges -> outputs clear without waiting for a clock edge.
2. Clean press: btn_in 0->1 and held -> db_level=1 and rise_tick=1 for exactly one cycle on the 7th edge after the first sampling edge; busy high for 4 cycles before that.
3. Bounce: btn_in high for 2 cycles, low for 1 cycle, then high and held -> the first attempt aborts with no rise_tick. db_level rises 7 edges after the final 0->1 sampling edge. With DEBOUNCE_BOUNCE_CNT_EN, bounce_cnt=1.
4. Release: from db_level=1, btn_in 1->0 and held -> fall_tick for one cycle and db_level=0 on the 7th edge; rise_tick stays 0 throughout.
5. Reset mid-wait: rst_n pulsed low while in WAIT_ZERO from ONE -> db_level=0 immediately, no fall_tick. After release with btn_in=0, the FSM stays in ZERO with busy=0.
6. Glitch train: 300 one-cycle-high glitches spaced 3 cycles apart -> db_level stays 0 and no ticks occur. With DEBOUNCE_BOUNCE_CNT_EN, bounce_cnt saturates at 255.
